// File: rtl/pc_src_unit_pkg.sv
// Shared types and defaults for the PC source unit: redirect FSM states and
// a width helper that never returns zero for single-cause configurations.
package pc_src_pkg;

  localparam int DEFAULT_WIDTH    = 32;
  localparam int DEFAULT_EXC_BASE = 253;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VEC_RD   = 2'd1,
    VEC_WAIT = 2'd2
  } state_e;

  // Index width for an N-entry selector; a single entry still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_src_unit_if.sv
// Bundle between the control/datapath side (master) and the PC source unit (slave).
interface pc_src_unit_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int NEXC  = 3
);
  import pc_src_pkg::*;

  localparam int SEL_W   = idx_width(NSRC);
  localparam int CAUSE_W = idx_width(NEXC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]      sel;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic                  cond_true;
  logic [NEXC-1:0]       exc_req;
  logic [7:0]            mem_data;
  logic                  mem_rd;
  logic [WIDTH-1:0]      mem_addr;
  logic [WIDTH-1:0]      pc;
  logic [WIDTH-1:0]      epc;
  logic [CAUSE_W-1:0]    exc_cause;
  logic                  busy;

  modport master (
    output src_data, sel, pc_write, pc_write_cond, cond_true, exc_req, mem_data,
    input  mem_rd, mem_addr, pc, epc, exc_cause, busy
  );

  modport slave (
    input  src_data, sel, pc_write, pc_write_cond, cond_true, exc_req, mem_data,
    output mem_rd, mem_addr, pc, epc, exc_cause, busy
  );

endinterface

// File: rtl/pc_src_unit_mux_n.sv
// Index mux over a flattened N-entry bus; flags indices beyond N so the
// caller can hold its register instead of loading an undefined value.
module mux_n
  import pc_src_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = idx_width(N)
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o,
  output logic               in_range_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(sel_i) == i) begin
        data_o = data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_range_o = (int'(sel_i) < N);

endmodule

// File: rtl/pc_src_unit.sv
// PC/EPC owner: selects the next PC from NSRC candidates and redirects to a
// one-byte handler address fetched from the exception vector table.
//
//   state    | meaning
//   IDLE     | normal PC loads, exception requests accepted
//   VEC_RD   | vector-table read strobe out, EPC/cause already captured
//   VEC_WAIT | memory byte valid, loaded into PC at the closing edge
module pc_src_unit
  import pc_src_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               NSRC     = 4,
  parameter int               NEXC     = 3,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               EXC_BASE = DEFAULT_EXC_BASE
) (
  input  logic         clk,
  input  logic         reset,
  pc_src_unit_if.slave bus
);

  localparam int SEL_W   = idx_width(NSRC);
  localparam int CAUSE_W = idx_width(NEXC);

  state_e             state_q;
  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   epc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic               mem_rd_q;
  logic               busy_q;

  logic [WIDTH-1:0]   pc_d;
  logic               sel_ok;
  logic               pc_load_d;
  logic               exc_any_d;
  logic [CAUSE_W-1:0] exc_cause_d;

  mux_n #(
    .WIDTH (WIDTH),
    .N     (NSRC),
    .SEL_W (SEL_W)
  ) u_mux (
    .data_i     (bus.src_data),
    .sel_i      (bus.sel),
    .data_o     (pc_d),
    .in_range_o (sel_ok)
  );

  assign pc_load_d = (bus.pc_write | (bus.pc_write_cond & bus.cond_true)) & sel_ok;
  assign exc_any_d = |bus.exc_req;

  // Scan downward so the lowest set request line wins.
  always_comb begin
    exc_cause_d = '0;
    for (int i = NEXC - 1; i >= 0; i--) begin
      if (bus.exc_req[i]) begin
        exc_cause_d = CAUSE_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      epc_q    <= '0;
      cause_q  <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (exc_any_d) begin
            epc_q    <= pc_q - WIDTH'(4);
            cause_q  <= exc_cause_d;
            state_q  <= VEC_RD;
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (pc_load_d) begin
            pc_q <= pc_d;
          end
        end
        VEC_RD: begin
          state_q  <= VEC_WAIT;
          mem_rd_q <= 1'b0;
        end
        VEC_WAIT: begin
          pc_q    <= {{(WIDTH-8){1'b0}}, bus.mem_data};
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr  = (state_q == VEC_RD)
                       ? (WIDTH'(EXC_BASE) + {{(WIDTH-CAUSE_W){1'b0}}, cause_q})
                       : '0;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.busy      = busy_q;
  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.exc_cause = cause_q;

endmodule

// File: tb/tb_pc_src_unit.sv
// Directed bench for pc_src_unit: normal/conditional loads, out-of-range select,
// exception redirect timing, dropped requests and mid-redirect reset.
module tb_pc_src_unit;

  localparam int WIDTH = 32;
  localparam int NSRC  = 3;
  localparam int NEXC  = 3;
  localparam logic [WIDTH-1:0] RPC = 32'h0000_0400;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pc_src_unit_if #(.WIDTH(WIDTH), .NSRC(NSRC), .NEXC(NEXC)) bus ();

  pc_src_unit #(
    .WIDTH    (WIDTH),
    .NSRC     (NSRC),
    .NEXC     (NEXC),
    .RESET_PC (RPC),
    .EXC_BASE (253)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int idx, input logic [WIDTH-1:0] v);
    bus.src_data[idx*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.src_data      = '0;
    bus.sel           = '0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.cond_true     = 1'b0;
    bus.exc_req       = '0;
    bus.mem_data      = '0;
    repeat (3) step();
    reset = 1'b1;
    step();

    check("rst_pc",     bus.pc, RPC);
    check("rst_epc",    bus.epc, 32'h0);
    check("rst_busy",   32'(bus.busy), 32'h0);
    check("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("rst_addr",   bus.mem_addr, 32'h0);
    check("rst_cause",  32'(bus.exc_cause), 32'h0);

    // unconditional load from candidate 2
    set_src(0, 32'h0000_1111);
    set_src(1, 32'h0000_2222);
    set_src(2, 32'h0000_1234);
    bus.sel = 2'd2;
    bus.pc_write = 1'b1;
    step();
    check("load_sel2", bus.pc, 32'h0000_1234);

    // select index == NSRC: hold
    set_src(2, 32'h0000_5678);
    bus.sel = 2'd3;
    step();
    check("sel_oor_hold", bus.pc, 32'h0000_1234);
    bus.pc_write = 1'b0;

    // conditional load, condition false then true
    set_src(1, 32'h0000_0080);
    bus.sel = 2'd1;
    bus.pc_write_cond = 1'b1;
    bus.cond_true = 1'b0;
    step();
    check("cond_false", bus.pc, 32'h0000_1234);
    bus.cond_true = 1'b1;
    step();
    check("cond_true", bus.pc, 32'h0000_0080);
    bus.pc_write_cond = 1'b0;
    bus.cond_true = 1'b0;

    // reach pc=0x108 then take cause 1
    set_src(0, 32'h0000_0108);
    bus.sel = 2'd0;
    bus.pc_write = 1'b1;
    step();
    check("pc_0x108", bus.pc, 32'h0000_0108);
    bus.pc_write = 1'b0;
    bus.exc_req = 3'b110;
    step();
    check("e0_epc",    bus.epc, 32'h0000_0104);
    check("e0_cause",  32'(bus.exc_cause), 32'd1);
    check("e0_mem_rd", 32'(bus.mem_rd), 32'h1);
    check("e0_addr",   bus.mem_addr, 32'd254);
    check("e0_busy",   32'(bus.busy), 32'h1);
    check("e0_pc",     bus.pc, 32'h0000_0108);
    bus.exc_req = '0;
    bus.mem_data = 8'h9C;
    step();
    check("e1_mem_rd", 32'(bus.mem_rd), 32'h0);
    check("e1_addr",   bus.mem_addr, 32'h0);
    check("e1_busy",   32'(bus.busy), 32'h1);
    check("e1_pc",     bus.pc, 32'h0000_0108);
    step();
    check("e2_pc",     bus.pc, 32'h0000_009C);
    check("e2_busy",   32'(bus.busy), 32'h0);

    // exception together with pc_write: exception wins, cause 0
    set_src(0, 32'h0000_AAAA);
    bus.sel = 2'd0;
    bus.pc_write = 1'b1;
    bus.exc_req = 3'b001;
    step();
    check("drop_pc",    bus.pc, 32'h0000_009C);
    check("drop_epc",   bus.epc, 32'h0000_0098);
    check("drop_cause", 32'(bus.exc_cause), 32'd0);
    check("drop_addr",  bus.mem_addr, 32'd253);
    // requests and writes while busy are ignored, including at the return edge
    bus.exc_req = 3'b100;
    bus.mem_data = 8'h55;
    step();
    check("busy_cause", 32'(bus.exc_cause), 32'd0);
    check("busy_epc",   bus.epc, 32'h0000_0098);
    check("busy_pc",    bus.pc, 32'h0000_009C);
    step();
    check("ret_pc",     bus.pc, 32'h0000_0055);
    check("ret_busy",   32'(bus.busy), 32'h0);
    bus.exc_req = '0;
    bus.pc_write = 1'b0;
    step();
    check("no_redo_busy",  32'(bus.busy), 32'h0);
    check("no_redo_cause", 32'(bus.exc_cause), 32'd0);
    check("no_redo_pc",    bus.pc, 32'h0000_0055);

    // reset during VEC_WAIT aborts the redirect
    bus.exc_req = 3'b001;
    step();
    bus.exc_req = '0;
    bus.mem_data = 8'h77;
    step();
    check("pre_rst_busy", 32'(bus.busy), 32'h1);
    reset = 1'b0;
    #1;
    check("abort_pc",   bus.pc, RPC);
    check("abort_epc",  bus.epc, 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    step();
    reset = 1'b1;
    step();
    check("abort_no_load", bus.pc, RPC);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
